adc_pipe_arbiter: RTL and testbench

- Shares the single bulk-transfer pipe FIFO (endpoint 0xA3 path) between all N_ADC oversampled ADC channels.
- Latches each enabled channel's latest sample, picks channels round-robin, and writes two-word tagged frames into the pipe FIFO write port.
- Sits between the ADC controller's data-valid/data buses and pipe_tx_fifo on the clk50 domain; the channel enable mask comes from a frontpanel wire-in.

---
 rtl/adc_pipe_arbiter.sv | 157 +++++++++++++++
 tb/tb_adc_pipe_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pipe_arbiter.sv
// adc_pipe_arbiter: latches ADC samples per channel and packs them round-robin into two-word tagged pipe FIFO frames.
// Latency: a strobe captured at edge k is granted at k+1; the header is written at k+2 and the data word at k+3.
// Backpressure: fifo_full_in holds the frame in place; a new sample on a channel that is still pending overwrites it and counts a drop.
module adc_pipe_arbiter #(
  parameter int N_ADC  = 6,
  parameter int W_ADC  = 18,
  parameter int W_DROP = 6
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [N_ADC-1:0] chan_en_in,
  input  logic [N_ADC-1:0] adc_data_valid_in,
  input  logic [W_ADC-1:0] adc_data_a_in,
  input  logic [W_ADC-1:0] adc_data_b_in,
  input  logic             fifo_full_in,
  output logic             fifo_wr_en_out,
  output logic [15:0]      fifo_data_out,
  output logic             drop_any_out,
  output logic             busy_out
);

  localparam int CW = (N_ADC > 1) ? $clog2(N_ADC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                rr_q, rr_d;
  logic [N_ADC-1:0]             pend_q, pend_d;
  logic [N_ADC-1:0][W_ADC-1:0]  latch_q, latch_d;
  logic [N_ADC-1:0][W_DROP-1:0] drop_q, drop_d;
  logic                         drop_any_q, drop_any_d;
  logic [15:0]                  data_q, data_d;
  logic [15:0]                  next_q, next_d;

  logic                         gnt_found;
  logic [CW-1:0]                gnt_idx;
  logic                         do_grant;
  logic [W_ADC-1:0]             gnt_raw;
  logic [W_DROP-1:0]            gnt_drop;
  logic [17:0]                  gnt_s18;
  logic [5:0]                   gnt_drop6;

  assign gnt_raw  = latch_q[gnt_idx];
  assign gnt_drop = drop_q[gnt_idx];

  // Align the granted sample to an 18-bit field: keep the MSBs, pad missing LSBs with zero.
  if (W_ADC >= 18) begin : g_samp_trunc
    assign gnt_s18 = gnt_raw[W_ADC-1 -: 18];
  end else begin : g_samp_pad
    assign gnt_s18 = {gnt_raw, {(18 - W_ADC){1'b0}}};
  end

  // Fit the drop count into the 6-bit frame field: saturate wide counters, zero-extend narrow ones.
  if (W_DROP > 6) begin : g_drop_sat
    assign gnt_drop6 = (gnt_drop > W_DROP'(63)) ? 6'h3f : gnt_drop[5:0];
  end else begin : g_drop_ext
    assign gnt_drop6 = 6'(gnt_drop);
  end

  // Round-robin search: the first pending channel at or after rr_q wins (lowest offset assigned last).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = N_ADC - 1; k >= 0; k--) begin
      if (pend_q[CW'((int'(rr_q) + k) % N_ADC)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'((int'(rr_q) + k) % N_ADC);
      end
    end
  end

  // Next-state: frame FSM, grant bookkeeping, then per-channel capture / overwrite / enable masking.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    pend_d     = pend_q;
    latch_d    = latch_q;
    drop_d     = drop_q;
    drop_any_d = drop_any_q;
    data_d     = data_q;
    next_d     = next_q;
    do_grant   = 1'b0;

    case (state_q)
      IDLE: do_grant = gnt_found;
      HDR: begin
        if (!fifo_full_in) begin
          state_d = DATA;
          data_d  = next_q;
        end
      end
      DATA: begin
        if (!fifo_full_in) begin
          if (gnt_found) do_grant = 1'b1;
          else           state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The data word is built at grant time so HDR->DATA is a plain register move.
    if (do_grant) begin
      state_d         = HDR;
      rr_d            = (gnt_idx == CW'(N_ADC - 1)) ? '0 : gnt_idx + 1'b1;
      data_d          = {2'b10, 4'(gnt_idx), gnt_s18[17:8]};
      next_d          = {2'b01, gnt_drop6, gnt_s18[7:0]};
      pend_d[gnt_idx] = 1'b0;
      drop_d[gnt_idx] = '0;
    end

    for (int i = 0; i < N_ADC; i++) begin
      if (adc_data_valid_in[i] && chan_en_in[i]) begin
        latch_d[i] = (i < N_ADC / 2) ? adc_data_a_in : adc_data_b_in;
        // A sample granted on this same edge was already snapshotted, so it is not a drop.
        if (pend_q[i] && !(do_grant && gnt_idx == CW'(i))) begin
          if (drop_q[i] != {W_DROP{1'b1}}) drop_d[i] = drop_q[i] + 1'b1;
          drop_any_d = 1'b1;
        end
        pend_d[i] = 1'b1;
      end
      if (!chan_en_in[i]) pend_d[i] = 1'b0;
    end
  end

  // State register with asynchronous clear; a reset mid-frame simply truncates the frame.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      pend_q     <= '0;
      latch_q    <= '0;
      drop_q     <= '0;
      drop_any_q <= 1'b0;
      data_q     <= '0;
      next_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
      latch_q    <= latch_d;
      drop_q     <= drop_d;
      drop_any_q <= drop_any_d;
      data_q     <= data_d;
      next_q     <= next_d;
    end
  end

  assign fifo_wr_en_out = ((state_q == HDR) || (state_q == DATA)) && !fifo_full_in;
  assign fifo_data_out  = data_q;
  assign drop_any_out   = drop_any_q;
  assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_adc_pipe_arbiter.sv
// Bench for adc_pipe_arbiter: scenario tasks drive strobes and compare written FIFO words against an expected queue.
module tb_adc_pipe_arbiter;

  localparam int N = 6;
  localparam int W = 18;
  localparam int WD = 6;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic [N-1:0]  chan_en_in;
  logic [N-1:0]  adc_data_valid_in;
  logic [W-1:0]  adc_data_a_in;
  logic [W-1:0]  adc_data_b_in;
  logic          fifo_full_in;
  logic          fifo_wr_en_out;
  logic [15:0]   fifo_data_out;
  logic          drop_any_out;
  logic          busy_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_dat[$];
  int          obs_edge[$];

  adc_pipe_arbiter #(.N_ADC(N), .W_ADC(W), .W_DROP(WD)) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .chan_en_in        (chan_en_in),
    .adc_data_valid_in (adc_data_valid_in),
    .adc_data_a_in     (adc_data_a_in),
    .adc_data_b_in     (adc_data_b_in),
    .fifo_full_in      (fifo_full_in),
    .fifo_wr_en_out    (fifo_wr_en_out),
    .fifo_data_out     (fifo_data_out),
    .drop_any_out      (drop_any_out),
    .busy_out          (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every word the FIFO will capture on the coming rising edge, tagged with that edge number.
  always @(negedge clk_in) begin
    if (fifo_wr_en_out === 1'b1) begin
      obs_dat.push_back(fifo_data_out);
      obs_edge.push_back(cyc + 1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] hdr_w(input int ch, input logic [17:0] s);
    logic [3:0] c4;
    c4 = ch[3:0];
    return {2'b10, c4, s[17:8]};
  endfunction

  function automatic logic [15:0] dat_w(input int d, input logic [17:0] s);
    logic [5:0] d6;
    d6 = d[5:0];
    return {2'b01, d6, s[7:0]};
  endfunction

  task automatic push_frame(input int ch, input logic [17:0] s, input int d);
    exp_q.push_back(hdr_w(ch, s));
    exp_q.push_back(dat_w(d, s));
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_dat.delete();
    obs_edge.delete();
  endtask

  task automatic strobe(input logic [N-1:0] mask, input logic [W-1:0] a, input logic [W-1:0] b);
    adc_data_a_in = a;
    adc_data_b_in = b;
    adc_data_valid_in = mask;
    tick();
    adc_data_valid_in = '0;
  endtask

  // Bounded wait for n observed words, then a few quiet cycles to catch extras.
  task automatic wait_words(input int n);
    for (int t = 0; t < 300 && obs_dat.size() < n; t++) tick();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    chan_en_in = '1;
    adc_data_valid_in = '0;
    adc_data_a_in = '0;
    adc_data_b_in = '0;
    fifo_full_in = 1'b0;
    tick();
    tick();
    checks++; if (fifo_wr_en_out !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en_out); end
    checks++; if (fifo_data_out !== 16'h0) begin failures++; $display("FAIL reset_data got %h want 0000", fifo_data_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy_out); end
    checks++; if (drop_any_out !== 1'b0) begin failures++; $display("FAIL reset_drop_any got %b want 0", drop_any_out); end
    reset_in = 1'b0;
    tick();
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL post_reset_busy got %b want 0", busy_out); end
  endtask

  task automatic test_single();
    int k;
    logic [15:0] e, o;
    clear_q();
    exp_q.push_back(16'h82AB);
    exp_q.push_back(16'h40CD);
    adc_data_a_in = 18'h2ABCD;
    adc_data_valid_in = 6'b000001;
    tick();
    k = cyc;
    adc_data_valid_in = '0;
    wait_words(2);
    checks++; if (obs_dat.size() !== 2) begin failures++; $display("FAIL single_count got %0d want 2", obs_dat.size()); end
    if (obs_edge.size() >= 2) begin
      checks++; if (obs_edge[0] !== k + 2) begin failures++; $display("FAIL single_hdr_edge got %0d want %0d", obs_edge[0], k + 2); end
      checks++; if (obs_edge[1] !== k + 3) begin failures++; $display("FAIL single_data_edge got %0d want %0d", obs_edge[1], k + 3); end
    end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL single_word got %h want %h", o, e); end
    end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL single_idle_busy got %b want 0", busy_out); end
  endtask

  task automatic test_round_robin();
    logic [17:0] sa, sb;
    logic [15:0] e, o;
    clear_q();
    sa = 18'(($urandom & 32'h3ffff));
    sb = 18'(($urandom & 32'h3ffff));
    push_frame(1, sa, 0);
    push_frame(3, sb, 0);
    push_frame(4, sb, 0);
    strobe(6'b011010, sa, sb);
    wait_words(6);
    checks++; if (obs_dat.size() !== 6) begin failures++; $display("FAIL rr_count got %0d want 6", obs_dat.size()); end
    if (obs_edge.size() >= 6) begin
      checks++; if (obs_edge[5] - obs_edge[0] !== 5) begin failures++; $display("FAIL rr_throughput got %0d want 5", obs_edge[5] - obs_edge[0]); end
    end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rr_word got %h want %h", o, e); end
    end
    clear_q();
    sa = 18'(($urandom & 32'h3ffff));
    sb = 18'(($urandom & 32'h3ffff));
    push_frame(0, sa, 0);
    push_frame(4, sb, 0);
    strobe(6'b010001, sa, sb);
    wait_words(4);
    checks++; if (obs_dat.size() !== 4) begin failures++; $display("FAIL rr_wrap_count got %0d want 4", obs_dat.size()); end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rr_wrap_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_enable();
    logic [17:0] sa, sb;
    logic [15:0] e, o;
    clear_q();
    chan_en_in = 6'b011111;
    for (int i = 0; i < 3; i++) strobe(6'b100000, 18'h0, 18'(18'h1000 + i));
    repeat (10) tick();
    checks++; if (obs_dat.size() !== 0) begin failures++; $display("FAIL en_masked_count got %0d want 0", obs_dat.size()); end
    checks++; if (drop_any_out !== 1'b0) begin failures++; $display("FAIL en_masked_drop got %b want 0", drop_any_out); end
    clear_q();
    chan_en_in = '1;
    sa = 18'h15A5A;
    sb = 18'h0F0F0;
    push_frame(0, sa, 0);
    fifo_full_in = 1'b1;
    strobe(6'b000001, sa, sb);
    tick();
    strobe(6'b100000, sa, sb);
    chan_en_in = 6'b011111;
    tick();
    tick();
    chan_en_in = '1;
    fifo_full_in = 1'b0;
    wait_words(2);
    checks++; if (obs_dat.size() !== 2) begin failures++; $display("FAIL en_cleared_count got %0d want 2", obs_dat.size()); end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL en_cleared_word got %h want %h", o, e); end
    end
    checks++; if (drop_any_out !== 1'b0) begin failures++; $display("FAIL en_cleared_drop got %b want 0", drop_any_out); end
  endtask

  task automatic test_drop();
    logic [17:0] s0, v1, v2, v3, v4;
    logic [15:0] e, o;
    clear_q();
    s0 = 18'h3C3C3; v1 = 18'h11111; v2 = 18'h22222; v3 = 18'h3ABCD; v4 = 18'h04567;
    push_frame(0, s0, 0);
    push_frame(2, v3, 2);
    fifo_full_in = 1'b1;
    strobe(6'b000001, s0, 18'h0);
    tick();
    strobe(6'b000100, v1, 18'h0);
    strobe(6'b000100, v2, 18'h0);
    strobe(6'b000100, v3, 18'h0);
    tick();
    checks++; if (drop_any_out !== 1'b1) begin failures++; $display("FAIL drop_sticky got %b want 1", drop_any_out); end
    checks++; if (obs_dat.size() !== 0) begin failures++; $display("FAIL drop_full_writes got %0d want 0", obs_dat.size()); end
    fifo_full_in = 1'b0;
    wait_words(4);
    strobe(6'b000100, v4, 18'h0);
    push_frame(2, v4, 0);
    wait_words(6);
    checks++; if (obs_dat.size() !== 6) begin failures++; $display("FAIL drop_count got %0d want 6", obs_dat.size()); end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL drop_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] sa, sb;
    logic [15:0] e, o;
    clear_q();
    sa = 18'(($urandom & 32'h3ffff));
    sb = 18'(($urandom & 32'h3ffff));
    push_frame(3, sb, 0);
    push_frame(4, sb, 0);
    push_frame(5, sb, 0);
    push_frame(0, sa, 0);
    push_frame(1, sa, 0);
    push_frame(2, sa, 0);
    adc_data_a_in = sa;
    adc_data_b_in = sb;
    for (int i = 0; i < 60; i++) begin
      adc_data_valid_in = (i == 0) ? 6'b111111 : 6'b000000;
      fifo_full_in = (i % 2 == 1);
      tick();
    end
    adc_data_valid_in = '0;
    fifo_full_in = 1'b0;
    wait_words(12);
    checks++; if (obs_dat.size() !== 12) begin failures++; $display("FAIL bp_count got %0d want 12", obs_dat.size()); end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL bp_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] s1, s3;
    logic [15:0] e, o;
    clear_q();
    s1 = 18'h2468A; s3 = 18'h13579;
    strobe(6'b000010, s1, 18'h0);
    for (int t = 0; t < 20 && obs_dat.size() < 1; t++) tick();
    checks++; if (busy_out !== 1'b1) begin failures++; $display("FAIL mid_busy_before got %b want 1", busy_out); end
    reset_in = 1'b1;
    #1;
    checks++; if (fifo_wr_en_out !== 1'b0) begin failures++; $display("FAIL mid_reset_wr_en got %b want 0", fifo_wr_en_out); end
    checks++; if (fifo_data_out !== 16'h0) begin failures++; $display("FAIL mid_reset_data got %h want 0000", fifo_data_out); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got %b want 0", busy_out); end
    tick();
    tick();
    reset_in = 1'b0;
    tick();
    checks++; if (obs_dat.size() !== 1) begin failures++; $display("FAIL mid_truncated_count got %0d want 1", obs_dat.size()); end
    if (obs_dat.size() > 0) begin
      o = obs_dat.pop_front();
      checks++; if (o !== hdr_w(1, s1)) begin failures++; $display("FAIL mid_truncated_hdr got %h want %h", o, hdr_w(1, s1)); end
    end
    checks++; if (drop_any_out !== 1'b0) begin failures++; $display("FAIL mid_drop_cleared got %b want 0", drop_any_out); end
    clear_q();
    push_frame(3, s3, 0);
    strobe(6'b001000, 18'h0, s3);
    wait_words(2);
    checks++; if (obs_dat.size() !== 2) begin failures++; $display("FAIL post_reset_count got %0d want 2", obs_dat.size()); end
    while (exp_q.size() > 0 && obs_dat.size() > 0) begin
      e = exp_q.pop_front(); o = obs_dat.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL post_reset_word got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_enable();
    test_drop();
    test_backpressure();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
